tick_sched: RTL and testbench

TICK_SCHED -- requirements
Module: tick_sched

---
 rtl/tick_sched.sv | 168 ++++++++++++++++
 tb/tb_tick_sched.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/tick_sched.sv
`default_nettype none
// ============================================================================
// Module      : tick_sched
// Description : Multi-channel periodic tick scheduler. A shared prescaler
//               produces a base strobe every 2^PRE cycles. Each channel
//               counts base strobes up to its programmed period and emits a
//               one-cycle tick on terminal count. Channels are reprogrammed
//               through a valid/ready configuration port; each write spends
//               one APPLY cycle clearing the target channel's counter.
//               Optional build macro TICK_SCHED_ONESHOT_EN adds a per-channel
//               one-shot mode (cfg_oneshot input).
// Revision    : 1.0 - initial release
// ============================================================================
module tick_sched #(
    parameter int NCH = 4,
    parameter int PW  = 16,
    parameter int PRE = 2,
    localparam int c_chw = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [c_chw-1:0] cfg_ch,
    input  logic [PW-1:0]    cfg_period,
    input  logic             cfg_en,
`ifdef TICK_SCHED_ONESHOT_EN
    input  logic             cfg_oneshot,
`endif
    output logic [NCH-1:0]   tick,
    output logic             running
);

    localparam logic [1:0] c_st_stop  = 2'd0;
    localparam logic [1:0] c_st_run   = 2'd1;
    localparam logic [1:0] c_st_apply = 2'd2;

    logic [1:0]       r_state;
    logic [c_chw-1:0] r_apply_ch;
    logic             r_apply_hit;

    logic w_accept;
    logic w_wr_valid;
    logic w_active;
    logic w_strobe;

    // Counting happens only while running, including the APPLY cycle.
    assign w_active   = run && ((r_state == c_st_run) || (r_state == c_st_apply));
    assign running    = w_active;
    assign cfg_ready  = !rst && (r_state != c_st_apply);
    assign w_accept   = cfg_valid && cfg_ready;
    // Writes to non-existent channels are accepted but touch nothing.
    assign w_wr_valid = (int'(cfg_ch) < NCH);

    // Control FSM; remembers which channel the current APPLY cycle belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_stop;
            r_apply_ch  <= '0;
            r_apply_hit <= 1'b0;
        end else begin
            case (r_state)
                c_st_stop: begin
                    if (w_accept)  r_state <= c_st_apply;
                    else if (run)  r_state <= c_st_run;
                end
                c_st_run: begin
                    if (w_accept)  r_state <= c_st_apply;
                    else if (!run) r_state <= c_st_stop;
                end
                c_st_apply: begin
                    r_state <= run ? c_st_run : c_st_stop;
                end
                default: begin
                    r_state <= c_st_stop;
                end
            endcase
            if (w_accept) begin
                r_apply_ch  <= cfg_ch;
                r_apply_hit <= w_wr_valid;
            end
        end
    end

    generate
        if (PRE == 0) begin : g_presc_none
            assign w_strobe = w_active;
        end else begin : g_presc
            logic [PRE-1:0] r_presc;

            // Free-running prescaler; frozen whenever the scheduler is not active.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_presc <= '0;
                end else if (w_active) begin
                    r_presc <= r_presc + 1'b1;
                end
            end

            assign w_strobe = w_active && (&r_presc);
        end
    endgenerate

    generate
        for (genvar i = 0; i < NCH; i++) begin : g_ch
            logic [PW-1:0] r_period;
            logic [PW-1:0] r_cnt;
            logic          r_en;
            logic          r_tick;
            logic          w_sel;
            logic          w_hold;
            logic          w_tc;

            assign w_sel  = w_accept && w_wr_valid && (cfg_ch == c_chw'(i));
            assign w_hold = (r_state == c_st_apply) && r_apply_hit && (r_apply_ch == c_chw'(i));
            // Counter never exceeds period-1, so it cannot overflow even at 2^PW-1.
            assign w_tc   = (r_cnt == (r_period - 1'b1));
            assign tick[i] = r_tick;

`ifdef TICK_SCHED_ONESHOT_EN
            logic r_oneshot;

            // One-shot flag travels with every write to this channel.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_oneshot <= 1'b0;
                end else if (w_sel) begin
                    r_oneshot <= cfg_oneshot;
                end
            end
`endif

            // Channel counter: a write (or its APPLY cycle) overrides any terminal count.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_period <= '0;
                    r_cnt    <= '0;
                    r_en     <= 1'b0;
                    r_tick   <= 1'b0;
                end else begin
                    r_tick <= 1'b0;
                    if (w_sel) begin
                        r_period <= cfg_period;
                        r_en     <= cfg_en;
                        r_cnt    <= '0;
                    end else if (w_hold) begin
                        r_cnt <= '0;
                    end else if (w_strobe && r_en && (r_period != '0)) begin
                        if (w_tc) begin
                            r_cnt  <= '0;
                            r_tick <= 1'b1;
`ifdef TICK_SCHED_ONESHOT_EN
                            if (r_oneshot) begin
                                r_en <= 1'b0;
                            end
`endif
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_tick_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_tick_sched
// Description : Directed self-checking bench for tick_sched (NCH=4, PW=8,
//               PRE=2). Expected tick times are hand-derived from a base
//               strobe every 4 cycles. Define TICK_SCHED_ONESHOT_EN to also
//               exercise the one-shot channel mode.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tick_sched;

    localparam int NCH = 4;
    localparam int PW  = 8;
    localparam int PRE = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           run;
    logic           cfg_valid;
    logic           cfg_ready;
    logic [1:0]     cfg_ch;
    logic [PW-1:0]  cfg_period;
    logic           cfg_en;
    logic           cfg_oneshot;
    logic [NCH-1:0] tick;
    logic           running;

    int             n_checks = 0;
    int             n_fail   = 0;
    int             cyc      = 0;
    logic [NCH-1:0] seen;

    tick_sched #(.NCH(NCH), .PW(PW), .PRE(PRE)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_period (cfg_period),
        .cfg_en     (cfg_en),
`ifdef TICK_SCHED_ONESHOT_EN
        .cfg_oneshot(cfg_oneshot),
`endif
        .tick       (tick),
        .running    (running)
    );

    always #5 clk = ~clk;

    // One clock edge; outputs are looked at 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        seen = seen | tick;
    endtask

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Drives one write for a single edge; acc returns the accepting edge.
    task automatic cfg_write(input int ch, input int period, input logic en,
                             input logic os, output int acc);
        cfg_valid   = 1'b1;
        cfg_ch      = 2'(ch);
        cfg_period  = PW'(period);
        cfg_en      = en;
        cfg_oneshot = os;
        step();
        acc         = cyc;
        cfg_valid   = 1'b0;
    endtask

    // Steps until tick[ch] is seen; t = -1 if the budget runs out.
    task automatic wait_tick(input int ch, input int budget, output int t);
        t = -1;
        for (int k = 0; k < budget; k++) begin
            step();
            if (tick[ch]) begin
                t = cyc;
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, t, t2, ta, tb, tc, td, t0, t1, both, c1;

        rst = 1'b1; run = 1'b0; cfg_valid = 1'b0; cfg_ch = '0;
        cfg_period = '0; cfg_en = 1'b0; cfg_oneshot = 1'b0; seen = '0;

        // Reset state
        repeat (3) step();
        check_eq("rst_tick",    int'(tick),      0);
        check_eq("rst_running", int'(running),   0);
        check_eq("rst_ready",   int'(cfg_ready), 0);
        rst = 1'b0;
        #1;
        check_eq("ready_after_rst", int'(cfg_ready), 1);
        check_eq("stop_running",    int'(running),   0);

        // ch0 period 3 -> tick every 12 clk
        run = 1'b1;
        seen = '0;
        cfg_write(0, 3, 1'b1, 1'b0, a);
        check_eq("apply_ready",   int'(cfg_ready), 0);
        check_eq("apply_running", int'(running),   1);
        wait_tick(0, 40, t);
        check_eq("t0_first", t - a, 12);
        step();
        check_eq("t0_width", int'(tick[0]), 0);
        wait_tick(0, 40, t2);
        check_eq("t0_period", t2 - t, 12);
        check_eq("t0_others_quiet", int'(seen[3:1]), 0);

        // ch1 period 1, ch2 period 2
        cfg_write(1, 1, 1'b1, 1'b0, a);
        step();
        cfg_write(2, 2, 1'b1, 1'b0, a);
        step();
        wait_tick(1, 20, ta);
        wait_tick(1, 20, tb);
        check_eq("t1_period", tb - ta, 4);
        wait_tick(2, 20, tc);
        wait_tick(2, 20, td);
        check_eq("t2_period", td - tc, 8);
        both = 0; c1 = 0;
        for (int k = 0; k < 16; k++) begin
            step();
            if (tick[1] && tick[2]) both++;
            if (tick[1]) c1++;
        end
        check_eq("t12_coincident", both, 2);
        check_eq("t1_count16",     c1,   4);

        // Stop for 20 clk mid-period; 21 frozen edges incl. STOP->RUN
        wait_tick(0, 20, t0);
        repeat (4) step();
        run  = 1'b0;
        seen = '0;
        repeat (20) step();
        check_eq("stop_no_tick",     int'(seen),      0);
        check_eq("stop_running_low", int'(running),   0);
        check_eq("stop_ready",       int'(cfg_ready), 1);
        run = 1'b1;
        wait_tick(0, 40, t1);
        check_eq("resume_phase", t1 - t0, 33);

        // Rewrite ch0 period 5 exactly on its terminal-count edge
        repeat (11) step();
        cfg_write(0, 5, 1'b1, 1'b0, a);
        check_eq("tc_write_no_tick", int'(tick[0]),  0);
        check_eq("tc_write_ready",   int'(cfg_ready), 0);
        step();
        check_eq("ready_after_apply", int'(cfg_ready), 1);
        wait_tick(0, 40, t);
        check_eq("p5_after_apply", t - a, 20);

        // Period 0, then enable 0: ch0 silent
        cfg_write(0, 0, 1'b1, 1'b0, a);
        seen = '0;
        repeat (100) step();
        check_eq("p0_silent", int'(seen[0]), 0);
        cfg_write(0, 3, 1'b0, 1'b0, a);
        seen = '0;
        repeat (100) step();
        check_eq("en0_silent", int'(seen[0]), 0);
        check_eq("ch1_alive",  int'(seen[1]), 1);

        // Reset during APPLY
        cfg_write(1, 1, 1'b1, 1'b0, a);
        rst = 1'b1;
        step();
        check_eq("apply_rst_tick",    int'(tick),      0);
        check_eq("apply_rst_running", int'(running),   0);
        check_eq("apply_rst_ready",   int'(cfg_ready), 0);
        rst = 1'b0;
        #1;
        check_eq("apply_rst_ready_after", int'(cfg_ready), 1);
        seen = '0;
        repeat (40) step();
        check_eq("post_rst_running", int'(running), 1);
        check_eq("post_rst_no_tick", int'(seen),    0);

`ifdef TICK_SCHED_ONESHOT_EN
        // One-shot: exactly one tick 8 clk after APPLY
        run = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        run = 1'b1;
        cfg_write(3, 2, 1'b1, 1'b1, a);
        wait_tick(3, 30, t);
        check_eq("oneshot_first", t - a, 8);
        seen = '0;
        repeat (60) step();
        check_eq("oneshot_once", int'(seen[3]), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
